// File: rtl/rs_ser_pkg.sv
// Shared types and defaults for the RS symbol serializer scheduler.
package rs_ser_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, GAP} state_t;

  localparam int SYM_W_DEF   = 7;
  localparam int MAX_SYM_DEF = 127;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rs_rr_arb.sv
// Combinational round-robin pick: first valid index searching upward from rr_ptr+1.
module rs_rr_arb import rs_ser_pkg::*; #(
  parameter  int NREQ = 2,
  localparam int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IW-1:0]   rr_ptr,
  output logic [IW-1:0]   win,
  output logic            any
);

  int best;
  int off;

  always_comb begin
    win  = '0;
    any  = 1'b0;
    best = NREQ;
    off  = 0;
    for (int i = 0; i < NREQ; i++) begin
      // distance of candidate i from the slot just after the last winner
      off = (i + 2 * NREQ - int'(rr_ptr) - 1) % NREQ;
      if (req_valid[i] && off < best) begin
        best = off;
        win  = IW'(i);
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_ser_sched.sv
// Round-robin scheduler feeding whole codewords from NREQ sources into one
// symbol serializer, with inter-frame gap and serializer done-timeout.
module rs_ser_sched import rs_ser_pkg::*; #(
  parameter  int NREQ    = 2,
  parameter  int SYM_W   = SYM_W_DEF,
  parameter  int MAX_SYM = MAX_SYM_DEF,
  parameter  int GAP_CYC = 4,
  parameter  int DONE_TO = 64,
  localparam int IW      = idx_w(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*SYM_W-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic [SYM_W-1:0]      ser_data,
  output logic                  ser_load,
  input  logic                  ser_done,
  output logic [IW-1:0]         grant_id,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  len_err,
  output logic                  to_err
);

  // state | meaning
  // IDLE  | arbitrate among valid requesters
  // LOAD  | ready to grantee, waiting for its next symbol
  // WAIT  | symbol handed to serializer, waiting for ser_done
  // GAP   | forced idle between frames

  localparam int SCW = idx_w(MAX_SYM + 1);
  localparam int TW  = idx_w(DONE_TO);
  localparam int GW  = idx_w(GAP_CYC + 1);

  state_t          state, state_n;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   arb_win;
  logic            arb_any;
  logic [SCW-1:0]  sym_cnt;
  logic [TW-1:0]   to_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            last_q;
  logic            accept;
  logic            fd_n, le_n, to_n;

  rs_rr_arb #(.NREQ(NREQ)) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .win       (arb_win),
    .any       (arb_any)
  );

  assign busy = (state != IDLE);

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    fd_n      = 1'b0;
    le_n      = 1'b0;
    to_n      = 1'b0;
    req_ready = '0;
    case (state)
      IDLE: if (arb_any) state_n = LOAD;
      LOAD: begin
        req_ready[grant_id] = 1'b1;
        if (req_valid[grant_id]) begin
          accept  = 1'b1;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (ser_done) begin
          if (last_q) begin
            fd_n    = 1'b1;
            state_n = GAP;
          end else if (sym_cnt == SCW'(MAX_SYM)) begin
            // requester keeps the rest of its codeword and re-arbitrates
            le_n    = 1'b1;
            state_n = GAP;
          end else begin
            state_n = LOAD;
          end
        end else if (to_cnt == TW'(DONE_TO - 1)) begin
          to_n    = 1'b1;
          state_n = GAP;
        end
      end
      GAP:     if (gap_cnt <= GW'(1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= IW'(NREQ - 1);
      grant_id   <= '0;
      sym_cnt    <= '0;
      to_cnt     <= '0;
      gap_cnt    <= '0;
      last_q     <= 1'b0;
      ser_data   <= '0;
      ser_load   <= 1'b0;
      frame_done <= 1'b0;
      len_err    <= 1'b0;
      to_err     <= 1'b0;
    end else begin
      state      <= state_n;
      ser_load   <= accept;
      frame_done <= fd_n;
      len_err    <= le_n;
      to_err     <= to_n;
      if (state == IDLE && arb_any) begin
        grant_id <= arb_win;
        rr_ptr   <= arb_win;
        sym_cnt  <= '0;
      end
      if (accept) begin
        ser_data <= req_data[grant_id*SYM_W +: SYM_W];
        sym_cnt  <= sym_cnt + SCW'(1);
        last_q   <= req_last[grant_id];
        to_cnt   <= '0;
      end else if (state == WAIT && to_cnt != TW'(DONE_TO - 1)) begin
        to_cnt <= to_cnt + TW'(1);
      end
      // GAP_CYC of zero still spends the single cycle in GAP
      if (state != GAP && state_n == GAP)
        gap_cnt <= GW'(GAP_CYC);
      else if (state == GAP && gap_cnt != '0)
        gap_cnt <= gap_cnt - GW'(1);
    end
  end

endmodule
